// File: rtl/mips_fetch_pkg.sv
// Shared fetch-path types and constants for the paired fetch/decode boundary.
package mips_fetch_pkg;

   localparam int unsigned FQ_WIDTH = 32;
   localparam int unsigned FQ_DEPTH = 4;

   // Encodings of the decode-side take request
   localparam logic [1:0] TAKE_NONE = 2'd0;
   localparam logic [1:0] TAKE_ONE  = 2'd1;
   localparam logic [1:0] TAKE_TWO  = 2'd2;

   typedef struct packed {
      logic [FQ_WIDTH-1:0] pc;
      logic [FQ_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage : mips_fetch_pkg

// File: rtl/fetch_buf_mem.sv
// Queue storage: two write ports at consecutive addresses, two async read ports.
// Contents are intentionally not reset; validity is tracked by the queue count.
module fetch_buf_mem #(
   parameter int unsigned ENT_W = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [ENT_W-1:0]         wdata0,
   input  logic [ENT_W-1:0]         wdata1,
   input  logic [$clog2(DEPTH)-1:0] raddr0,
   input  logic [$clog2(DEPTH)-1:0] raddr1,
   output logic [ENT_W-1:0]         rdata0,
   output logic [ENT_W-1:0]         rdata1
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] waddr1;

   // Second write lands on the next slot, wrapping modulo DEPTH
   always_comb begin
      waddr1 = waddr + PTR_W'(1);
   end

   // Write both ports on the clock edge
   always_ff @(posedge clk) begin
      if (we0) mem[waddr]  <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   // Asynchronous reads of the two oldest slots
   always_comb begin
      rdata0 = mem[raddr0];
      rdata1 = mem[raddr1];
   end

endmodule : fetch_buf_mem

// File: rtl/fetch_pair_queue.sv
// Dual-issue in-order instruction queue between the paired fetch register and decode.
module fetch_pair_queue
   import mips_fetch_pkg::*;
#(
   parameter int unsigned WIDTH = FQ_WIDTH,
   parameter int unsigned DEPTH = FQ_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid1,
   input  logic             in_valid2,
   input  logic [WIDTH-1:0] in_pc1,
   input  logic [WIDTH-1:0] in_pc2,
   input  logic [WIDTH-1:0] in_instr1,
   input  logic [WIDTH-1:0] in_instr2,
   output logic             in_ready,
   output logic             out_valid1,
   output logic             out_valid2,
   output logic [WIDTH-1:0] out_pc1,
   output logic [WIDTH-1:0] out_pc2,
   output logic [WIDTH-1:0] out_instr1,
   output logic [WIDTH-1:0] out_instr2,
   input  logic [1:0]       out_take
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned ENT_W = 2 * WIDTH;

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr1;
   logic [CNT_W-1:0] count;
   logic [1:0]       npush;
   logic [1:0]       npop;
   logic             we0;
   logic             we1;
   logic [ENT_W-1:0] wdata0;
   logic [ENT_W-1:0] wdata1;
   logic [ENT_W-1:0] rdata0;
   logic [ENT_W-1:0] rdata1;
   logic [SUM_W-1:0] cnt_sum;

   fetch_buf_mem #(
      .ENT_W (ENT_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk    (clk),
      .we0    (we0),
      .we1    (we1),
      .waddr  (wr_ptr),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .raddr0 (rd_ptr),
      .raddr1 (rd_ptr1),
      .rdata0 (rdata0),
      .rdata1 (rdata1)
   );

   // Room for a full pair; depends on registered count only
   always_comb begin
      in_ready = (count <= CNT_W'(DEPTH - 2));
   end

   // Push control: a lone pair-2 offer is packed into the first write slot
   always_comb begin
      npush  = 2'd0;
      we0    = 1'b0;
      we1    = 1'b0;
      wdata0 = {in_pc1, in_instr1};
      wdata1 = {in_pc2, in_instr2};
      if (in_ready && !flush && !reset) begin
         npush = 2'(in_valid1) + 2'(in_valid2);
         we0   = in_valid1 | in_valid2;
         we1   = in_valid1 & in_valid2;
         if (!in_valid1) wdata0 = {in_pc2, in_instr2};
      end
   end

   // Pop count: take clamped to two and to the number of stored entries
   always_comb begin
      npop = 2'd0;
      if (count >= CNT_W'(2)) begin
         npop = (out_take >= TAKE_TWO) ? 2'd2 : out_take;
      end else if (count == CNT_W'(1)) begin
         npop = (out_take != TAKE_NONE) ? 2'd1 : 2'd0;
      end
   end

   // Pointer and occupancy update; reset over flush over normal operation
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(npop);
         wr_ptr <= wr_ptr + PTR_W'(npush);
         count  <= count + CNT_W'(npush) - CNT_W'(npop);
      end
   end

   // Present the two oldest entries, zeroing any slot that is not valid
   always_comb begin
      rd_ptr1    = rd_ptr + PTR_W'(1);
      out_valid1 = (count != '0);
      out_valid2 = (count >= CNT_W'(2));
      {out_pc1, out_instr1} = out_valid1 ? rdata0 : '0;
      {out_pc2, out_instr2} = out_valid2 ? rdata1 : '0;
   end

   // Occupancy after this cycle's push, used by the bound checks
   always_comb begin
      cnt_sum = SUM_W'(count) + SUM_W'(npush);
   end

   // Occupancy must stay within 0..DEPTH
   a_count_max : assert property (@(posedge clk) disable iff (reset)
      count <= CNT_W'(DEPTH));
   a_no_underflow : assert property (@(posedge clk) disable iff (reset || flush)
      cnt_sum >= SUM_W'(npop));
   a_no_overflow : assert property (@(posedge clk) disable iff (reset || flush)
      (cnt_sum - SUM_W'(npop)) <= SUM_W'(DEPTH));

endmodule : fetch_pair_queue

// File: doc/fetch_pair_queue.md
Name: fetch_pair_queue

Overview:
- Dual-issue instruction queue directly downstream of the paired PC/fetch register stage.
- Accepts up to two fetched (pc, instr) pairs per cycle and presents up to two of the oldest pairs per cycle to decode, in order.
- Its in_ready output drives the enable of the upstream PC-pair register.
- A flush input discards all contents on a redirect (branch or jump).

Parameters:
- WIDTH, 32: width of each pc and instr field.
- DEPTH, 4: number of entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all entries
- in_valid1  input  1  pair 1 offered (older of the two)
- in_valid2  input  1  pair 2 offered
- in_pc1, in_pc2  input  WIDTH  fetched PCs
- in_instr1, in_instr2  input  WIDTH  fetched instructions
- in_ready  output  1  room for two entries; upstream register enable
- out_valid1, out_valid2  output  1  oldest and second-oldest entries present
- out_pc1, out_pc2  output  WIDTH  PCs of the oldest two entries
- out_instr1, out_instr2  output  WIDTH  instructions of the oldest two entries
- out_take  input  2  number of entries decode consumes this cycle (0..2)

Behaviour:
- State: storage array, rd_ptr and wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset:
  - Sampled on the clk edge only.
  - Sets count=0 and both pointers=0; storage is not cleared.
  - Outputs after reset: in_ready=1, both out_valid=0, all out data=0.
- Priority: reset > flush > normal operation.
- in_ready:
  - Equals (DEPTH - count) >= 2.
  - Depends only on registered count, with no combinational path from out_take.
- Push:
  - Happens only when in_ready=1. Offers made while in_ready=0 are ignored; upstream holds its values.
  - Pushed entries are written in order: pair 1 first, then pair 2.
  - If only in_valid2=1, pair 2 alone is written, as a single entry.
  - npush = in_valid1 + in_valid2 when in_ready=1, else 0.
- Pop:
  - npop = min(out_take, count, 2). An out_take of 3, or a take beyond the valid entries, is clamped.
  - rd_ptr advances by npop, modulo DEPTH.
- Outputs (combinational from registered state only):
  - out_valid1 = count>=1; out_valid2 = count>=2.
  - Slot 1 = entry at rd_ptr; slot 2 = entry at rd_ptr+1 (mod DEPTH).
  - Any invalid slot drives zero on its pc and instr.
- No bypass:
  - An entry pushed in cycle N is first visible at the outputs in cycle N+1, so latency is 1 cycle.
  - Entries pushed this cycle cannot be popped in the same cycle.
- Simultaneous push and pop: count_next = count + npush - npop. Both pointers update in the same edge.
- Flush:
  - Next state is count=0, rd_ptr=0, wr_ptr=0.
  - Any push or pop in the flush cycle is discarded.
  - in_ready=1 in the following cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH. A two-entry push or read that straddles index DEPTH-1 → 0 must be correct.
- Invariant: count never exceeds DEPTH and never underflows. Assertions check both.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - the fetch_entry_t struct {pc, instr};
  - the FQ_DEPTH default;
  - take encodings TAKE_NONE=0, TAKE_ONE=1, TAKE_TWO=2.
- One natural sub-module, fetch_buf_mem: DEPTH-entry storage with two write ports (consecutive addresses) and two asynchronous read ports.
- The queue top level holds the pointers, count and control logic.

Test Plan:
- Reset then idle: assert reset 2 cycles → in_ready=1, out_valid1=0, out_valid2=0, out data 0.
- Fill then stall:
  - Push pairs (0x00,0xA0)/(0x04,0xA4), then (0x08,0xA8)/(0x0C,0xAC), with out_take=0 → count=4, in_ready=0.
  - A third offer (0x10,0xB0) is ignored.
  - Outputs show 0x00 and 0x04.
- Concurrent push/pop with wrap:
  - From count=2 with rd_ptr=3, push 2 and take 2 each cycle for 4 cycles.
  - Required: in-order PCs 0x00, 0x04, 0x08, ... at the outputs, count stays 2, pointers wrap 3→1.
- Single and clamped takes:
  - With count=3, out_take=3 → npop=2, leaving count=1 with out_valid2=0.
  - Then out_take=2 → count=0.
- Lone in_valid2: push only (0x20,0xC0) into an empty queue → next cycle out_valid1=1, out_pc1=0x20, out_valid2=0.
- Flush precedence:
  - With count=3, in one cycle assert flush, in_valid1/2=1 and out_take=2.
  - Required next cycle: count=0, in_ready=1, both out_valid=0.
  - A mid-operation reset gives the same result.
